cdc_handshake_rx: RTL and testbench
===================================

# cdc_handshake_rx

Receive-side endpoint of the team's toggle-handshake clock-domain crossing, sitting in the destination clock domain opposite the source-side pulse/request logic. It synchronizes an incoming request toggle and captures the accompanying data bus, which the sender holds stable until acknowledged. It presents each transfer as a valid/ready beat to local logic and returns an acknowledge toggle once the beat is consumed. It also counts completed transfers and flags sender protocol violations.

## Interface
- DATA_W, default 8: width of the transferred data word.
- SYNC_STAGES, default 2: synchronizer depth on `req_tog`; legal range 2..4.
- CNT_W, default 16: width of the transfer counter.

- sys_clk  in  1  destination-domain clock; all flops on rising edge.
- sys_rst_n  in  1  synchronous, active-low reset, sampled on `sys_clk`.
- req_tog  in  1  request toggle from the source domain (asynchronous); each level change is one request.
- req_data  in  DATA_W  source data (asynchronous); stable from the `req_tog` change until the sender sees `ack_tog` change.
- ack_tog  out  1  acknowledge toggle back to the source; one level change per completed transfer.
- out_valid  out  1  captured word available.
- out_data  out  DATA_W  captured word; stable while `out_valid`=1.
- out_ready  in  1  local consumer accepts the word when high with `out_valid`.
- xfer_cnt  out  CNT_W  completed transfers, wrapping.
- busy  out  1  high from edge detection until acknowledge issued.
- proto_err  out  1  sticky: request edge detected while a transfer is outstanding.

## Operation
- Synchronizer: `req_tog` passes through SYNC_STAGES flops (`sync[0..N-1]`). A history flop `req_hist` holds the previous `sync[N-1]`. `req_edge = sync[N-1] ^ req_hist`; `req_hist` updates every cycle.
- FSM states: IDLE, VALID.
  - IDLE: on `req_edge`, register `req_data` into `out_data`, set `out_valid`=1, go VALID. Otherwise stay.
  - VALID: when `out_ready`=1, clear `out_valid`, invert `ack_tog`, increment `xfer_cnt`, go IDLE, all on the same clock edge.
  - `req_edge` in VALID: set `proto_err`=1, which stays set until reset. The edge is otherwise ignored; the outstanding word and FSM are unaffected.
- `busy` = (state == VALID).
- `req_data` is sampled only on the IDLE edge-detect cycle, never through the synchronizer. The toggle delay guarantees settling.
- `xfer_cnt` wraps from 2^CNT_W−1 to 0 without flagging.
- Reset: all synchronizer and history flops go to 0, along with `ack_tog`, `out_valid`, `out_data`, `xfer_cnt`, `busy` and `proto_err`. The FSM returns to IDLE. The source endpoint must be reset with this block, because a mismatched toggle polarity after reset produces a spurious request.
- Reset asserted mid-transfer: the outstanding word is discarded and no acknowledge is issued.

## Timing
- `req_tog` changes before sys_clk edge k (meeting setup): `sync[N-1]` changes at edge k+N−1, and `out_valid`/`out_data` are registered at edge k+N. Request-to-valid latency is SYNC_STAGES+1 cycles (3 at default).
- `out_ready` high at the first `out_valid` cycle: `out_valid` is high for exactly 1 cycle, and `ack_tog` and `xfer_cnt` update at the next edge.
- Back-to-back transfers: at most one transfer per sender round trip; no receive-side buffering.
- `out_ready` may be held high permanently. `out_data` holds its last value after `out_valid` drops.

## Structure
- The shared package `cdc_pkg` holds:
  - the FSM state enum (`RX_IDLE`, `RX_VALID`);
  - the `SYNC_STAGES_MIN`=2 and `SYNC_STAGES_MAX`=4 constants, plus an elaboration-time range check.
- One sub-module, `bit_sync`: a parameterized N-flop single-bit synchronizer with synchronous active-low reset, reused by the source endpoint for `ack_tog`.
- FSM, capture register, counter and error flag live in the top module.

## Test plan
- Reset then single transfer: release reset at 200 ns, toggle `req_tog` 0→1 with `req_data`=0xA5, `out_ready`=1. Required: `out_valid` is a 1-cycle pulse 3 cycles after the toggle, `out_data`=0xA5, `ack_tog`=1, `xfer_cnt`=1.
- Backpressure: `out_ready`=0 for 10 cycles after `out_valid` rises with `req_data`=0x3C. Required: `out_valid`=1 and `out_data`=0x3C held for all 10 cycles, `ack_tog` unchanged. After `out_ready`=1, `ack_tog` toggles once and `xfer_cnt` increments once.
- Protocol violation: toggle `req_tog` twice with no ack while `out_ready`=0. Required: `proto_err`=1 and stays 1, the first word is retained, and only one ack follows when released.
- Counter wrap: CNT_W=4, run 17 handshaked transfers. Required: `xfer_cnt` reads 15 after 15 transfers, 0 after 16, 1 after 17; `proto_err`=0.
- Reset mid-transfer: assert `sys_rst_n`=0 while in VALID. Required: after the next edge, `out_valid`=0, `ack_tog`=0, `xfer_cnt`=0, `proto_err`=0, state IDLE.
- Depth sweep: SYNC_STAGES=4 single transfer. Required: latency of 5 cycles from the toggle to `out_valid`.

Source files
------------

// File: rtl/cdc_pkg.sv
// Shared definitions for the toggle-handshake clock-domain crossing endpoints.
package cdc_pkg;

    typedef enum logic [0:0] {
        RX_IDLE  = 1'b0,
        RX_VALID = 1'b1
    } rx_state_t;

    localparam int SYNC_STAGES_MIN = 2;
    localparam int SYNC_STAGES_MAX = 4;

    function automatic bit sync_stages_ok(input int n);
        return (n >= SYNC_STAGES_MIN) && (n <= SYNC_STAGES_MAX);
    endfunction

endpackage

// File: rtl/cdc_handshake_rx_if.sv
// Toggle request/acknowledge pair plus the local valid/ready beat of the receive endpoint.
interface cdc_handshake_rx_if #(
    parameter int DATA_W = 8
);
    logic              req_tog;
    logic [DATA_W-1:0] req_data;
    logic              ack_tog;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic              out_ready;

    modport slave (
        input  req_tog,
        input  req_data,
        input  out_ready,
        output ack_tog,
        output out_valid,
        output out_data
    );

    modport master (
        output req_tog,
        output req_data,
        output out_ready,
        input  ack_tog,
        input  out_valid,
        input  out_data
    );
endinterface

// File: rtl/bit_sync.sv
// N-flop single-bit synchronizer with synchronous active-low reset.
module bit_sync #(
    parameter int N = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);
    logic [N-1:0] sync_reg;
    logic [N-1:0] sync_next;

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_stage
            if (gi == 0) begin : g_first
                assign sync_next[gi] = d;
            end else begin : g_chain
                assign sync_next[gi] = sync_reg[gi-1];
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_reg <= '0;
        end else begin
            sync_reg <= sync_next;
        end
    end

    assign q = sync_reg[N-1];
endmodule

// File: rtl/cdc_handshake_rx.sv
// Receive endpoint of the toggle handshake: detects request edges, captures the held
// source word, offers it as a valid/ready beat and toggles the acknowledge when consumed.
module cdc_handshake_rx
    import cdc_pkg::*;
#(
    parameter int DATA_W      = 8,
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 16
) (
    input  logic               sys_clk,
    input  logic               sys_rst_n,
    cdc_handshake_rx_if.slave  rx,
    output logic [CNT_W-1:0]   xfer_cnt,
    output logic               busy,
    output logic               proto_err
);
    generate
        if (!sync_stages_ok(SYNC_STAGES)) begin : g_bad_depth
            $error("cdc_handshake_rx: SYNC_STAGES out of range");
        end
    endgenerate

    logic req_sync;
    logic req_hist_reg;
    logic req_edge;

    bit_sync #(
        .N(SYNC_STAGES)
    ) u_req_sync (
        .clk  (sys_clk),
        .rst_n(sys_rst_n),
        .d    (rx.req_tog),
        .q    (req_sync)
    );

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            req_hist_reg <= 1'b0;
        end else begin
            req_hist_reg <= req_sync;
        end
    end

    assign req_edge = req_sync ^ req_hist_reg;

    rx_state_t         state_reg, state_next;
    logic [DATA_W-1:0] out_data_reg, out_data_next;
    logic              ack_tog_reg, ack_tog_next;
    logic [CNT_W-1:0]  xfer_cnt_reg, xfer_cnt_next;
    logic              proto_err_reg, proto_err_next;

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            state_reg     <= RX_IDLE;
            out_data_reg  <= '0;
            ack_tog_reg   <= 1'b0;
            xfer_cnt_reg  <= '0;
            proto_err_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            out_data_reg  <= out_data_next;
            ack_tog_reg   <= ack_tog_next;
            xfer_cnt_reg  <= xfer_cnt_next;
            proto_err_reg <= proto_err_next;
        end
    end

    // req_data is sampled directly: the sender holds it from the toggle until the ack,
    // and the synchronizer delay guarantees it has settled by the edge-detect cycle.
    always_comb begin
        state_next     = state_reg;
        out_data_next  = out_data_reg;
        ack_tog_next   = ack_tog_reg;
        xfer_cnt_next  = xfer_cnt_reg;
        proto_err_next = proto_err_reg;
        case (state_reg)
            RX_IDLE: begin
                if (req_edge) begin
                    state_next    = RX_VALID;
                    out_data_next = rx.req_data;
                end
            end
            RX_VALID: begin
                if (req_edge) begin
                    proto_err_next = 1'b1;
                end
                if (rx.out_ready) begin
                    state_next    = RX_IDLE;
                    ack_tog_next  = ~ack_tog_reg;
                    xfer_cnt_next = xfer_cnt_reg + CNT_W'(1);
                end
            end
            default: begin
                state_next = RX_IDLE;
            end
        endcase
    end

    assign rx.out_valid = (state_reg == RX_VALID);
    assign rx.out_data  = out_data_reg;
    assign rx.ack_tog   = ack_tog_reg;
    assign busy         = (state_reg == RX_VALID);
    assign xfer_cnt     = xfer_cnt_reg;
    assign proto_err    = proto_err_reg;
endmodule

// File: tb/tb_cdc_handshake_rx.sv
// Directed bench: dut0 at default depth/width, dut1 with SYNC_STAGES=4 and CNT_W=4.
module tb_cdc_handshake_rx;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n0, rst_n1;
    logic [15:0] cnt0;
    logic [3:0]  cnt1;
    logic        busy0, busy1, perr0, perr1;

    cdc_handshake_rx_if #(.DATA_W(8)) if0 ();
    cdc_handshake_rx_if #(.DATA_W(8)) if1 ();

    cdc_handshake_rx #(.DATA_W(8), .SYNC_STAGES(2), .CNT_W(16)) dut0 (
        .sys_clk  (clk),
        .sys_rst_n(rst_n0),
        .rx       (if0),
        .xfer_cnt (cnt0),
        .busy     (busy0),
        .proto_err(perr0)
    );

    cdc_handshake_rx #(.DATA_W(8), .SYNC_STAGES(4), .CNT_W(4)) dut1 (
        .sys_clk  (clk),
        .sys_rst_n(rst_n1),
        .rx       (if1),
        .xfer_cnt (cnt1),
        .busy     (busy1),
        .proto_err(perr1)
    );

    int   checks = 0;
    int   errors = 0;
    logic exp_ack [2];

    typedef struct {
        int          dut;
        logic [7:0]  data;
        int          stall;
        int          exp_lat;
        logic [15:0] exp_cnt;
    } vec_t;

    vec_t vecs [7];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic logic valid_of(input int d);
        return (d == 0) ? if0.out_valid : if1.out_valid;
    endfunction
    function automatic logic [7:0] data_of(input int d);
        return (d == 0) ? if0.out_data : if1.out_data;
    endfunction
    function automatic logic ack_of(input int d);
        return (d == 0) ? if0.ack_tog : if1.ack_tog;
    endfunction
    function automatic logic [15:0] cnt_of(input int d);
        return (d == 0) ? cnt0 : {12'd0, cnt1};
    endfunction
    function automatic logic busy_of(input int d);
        return (d == 0) ? busy0 : busy1;
    endfunction
    function automatic logic perr_of(input int d);
        return (d == 0) ? perr0 : perr1;
    endfunction

    task automatic set_ready(input int d, input logic r);
        if (d == 0) if0.out_ready = r;
        else        if1.out_ready = r;
    endtask

    task automatic set_req(input int d, input logic [7:0] data);
        if (d == 0) begin
            if0.req_data = data;
            if0.req_tog  = ~if0.req_tog;
        end else begin
            if1.req_data = data;
            if1.req_tog  = ~if1.req_tog;
        end
    endtask

    task automatic wait_valid(input int d, output int lat);
        lat = 0;
        while (!valid_of(d) && lat < 40) begin
            tick();
            lat++;
        end
    endtask

    task automatic do_xfer(input int d, input logic [7:0] data, input int stall,
                           input int exp_lat, input logic [15:0] exp_cnt);
        int lat;
        set_ready(d, stall == 0);
        set_req(d, data);
        wait_valid(d, lat);
        chk("latency", lat, exp_lat);
        chk("out_data", data_of(d), data);
        chk("busy_high", busy_of(d), 1'b1);
        for (int i = 0; i < stall; i++) begin
            tick();
            chk("hold_valid", valid_of(d), 1'b1);
            chk("hold_data", data_of(d), data);
            chk("hold_ack", ack_of(d), exp_ack[d]);
        end
        if (stall > 0) set_ready(d, 1'b1);
        tick();
        exp_ack[d] = ~exp_ack[d];
        chk("valid_drop", valid_of(d), 1'b0);
        chk("ack_tog", ack_of(d), exp_ack[d]);
        chk("xfer_cnt", cnt_of(d), exp_cnt);
        chk("data_kept", data_of(d), data);
        chk("busy_low", busy_of(d), 1'b0);
        $display("xfer dut%0d data=%02h stall=%0d lat=%0d cnt=%0d", d, data, stall, lat, cnt_of(d));
    endtask

    initial begin
        int lat;
        vecs[0] = '{0, 8'hA5, 0,  3, 16'd1};
        vecs[1] = '{0, 8'h3C, 10, 3, 16'd2};
        vecs[2] = '{0, 8'h5A, 3,  3, 16'd3};
        vecs[3] = '{1, 8'h96, 0,  5, 16'd1};
        vecs[4] = '{0, 8'hFF, 0,  3, 16'd4};
        vecs[5] = '{0, 8'h00, 1,  3, 16'd5};
        vecs[6] = '{0, 8'h81, 2,  3, 16'd6};

        rst_n0 = 1'b0;
        rst_n1 = 1'b0;
        if0.req_tog = 1'b0; if0.req_data = 8'h00; if0.out_ready = 1'b0;
        if1.req_tog = 1'b0; if1.req_data = 8'h00; if1.out_ready = 1'b0;
        exp_ack[0] = 1'b0;
        exp_ack[1] = 1'b0;

        #150;
        for (int d = 0; d < 2; d++) begin
            chk("rst_valid", valid_of(d), 1'b0);
            chk("rst_ack", ack_of(d), 1'b0);
            chk("rst_cnt", cnt_of(d), 16'd0);
            chk("rst_perr", perr_of(d), 1'b0);
            chk("rst_busy", busy_of(d), 1'b0);
            chk("rst_data", data_of(d), 8'h00);
        end
        #50;
        rst_n0 = 1'b1;
        rst_n1 = 1'b1;
        tick();

        for (int v = 0; v < 7; v++) begin
            do_xfer(vecs[v].dut, vecs[v].data, vecs[v].stall, vecs[v].exp_lat, vecs[v].exp_cnt);
            repeat (2) tick();
        end

        // Second request while the first word is still outstanding.
        set_ready(0, 1'b0);
        set_req(0, 8'h11);
        wait_valid(0, lat);
        chk("perr_latency", lat, 3);
        chk("perr_before", perr0, 1'b0);
        set_req(0, 8'h22);
        repeat (6) tick();
        chk("perr_set", perr0, 1'b1);
        chk("perr_valid", if0.out_valid, 1'b1);
        chk("perr_first_word", if0.out_data, 8'h11);
        chk("perr_no_ack", if0.ack_tog, exp_ack[0]);
        set_ready(0, 1'b1);
        tick();
        exp_ack[0] = ~exp_ack[0];
        chk("perr_ack", if0.ack_tog, exp_ack[0]);
        chk("perr_cnt", cnt0, 16'd7);
        repeat (8) tick();
        chk("perr_single_ack", if0.ack_tog, exp_ack[0]);
        chk("perr_no_revalid", if0.out_valid, 1'b0);
        chk("perr_sticky", perr0, 1'b1);
        chk("perr_cnt_stable", cnt0, 16'd7);
        $display("xfer dut0 protocol violation sequence perr=%0b cnt=%0d", perr0, cnt0);

        // Reset while a word is outstanding; the source endpoint resets alongside.
        set_ready(0, 1'b0);
        set_req(0, 8'h77);
        wait_valid(0, lat);
        chk("midrst_busy", busy0, 1'b1);
        rst_n0 = 1'b0;
        if0.req_tog = 1'b0;
        tick();
        chk("midrst_valid", if0.out_valid, 1'b0);
        chk("midrst_ack", if0.ack_tog, 1'b0);
        chk("midrst_cnt", cnt0, 16'd0);
        chk("midrst_perr", perr0, 1'b0);
        chk("midrst_busy_low", busy0, 1'b0);
        exp_ack[0] = 1'b0;
        rst_n0 = 1'b1;
        repeat (5) tick();
        chk("midrst_no_spurious", if0.out_valid, 1'b0);
        $display("xfer dut0 reset mid-transfer ack=%0b cnt=%0d", if0.ack_tog, cnt0);
        do_xfer(0, 8'hC3, 0, 3, 16'd1);

        // Counter wrap on the 4-bit, depth-4 instance (it already holds one transfer).
        for (int k = 2; k <= 17; k++) begin
            do_xfer(1, 8'(k * 7), 0, 5, 16'(k % 16));
        end
        chk("wrap_perr", perr1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
